// File: rtl/lfsr_crypt_pkg.sv
// Shared constants, tap table and state encoding for the LFSR stream cipher engine.
package lfsr_crypt_pkg;

    localparam int PKG_LFSR_W   = 7;
    localparam int PKG_NUM_PTRN = 9;

    localparam logic [7:0] ASCII_OFFSET = 8'h20;

    // Entry 0 sits in the least significant slot.
    localparam logic [PKG_NUM_PTRN-1:0][PKG_LFSR_W-1:0] LFSR_PTRN = {
        7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
    };

    typedef enum logic [2:0] {IDLE, SEED, TRAIN, RUN, DONE} state_t;

    function automatic logic [PKG_LFSR_W-1:0] ptrn_tap(input logic [3:0] idx);
        if (int'(idx) < PKG_NUM_PTRN) return LFSR_PTRN[idx];
        return LFSR_PTRN[0];
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci-style LFSR: shifts left, feedback is the parity of the tapped bits.
module lfsr_gen #(
    parameter int LFSR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    input  logic [LFSR_W-1:0] tap,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (reset)
            state <= LFSR_W'(1);
        else if (load)
            state <= seed;
        else if (step)
            state <= {state[LFSR_W-2:0], ^(state & tap)};
    end

endmodule

// File: rtl/lfsr_crypt_engine.sv
// Streams a padded message through a byte memory port, XORing it with an LFSR keystream;
// decrypt mode recovers seed and taps from the all-space preamble.
module lfsr_crypt_engine
    import lfsr_crypt_pkg::*;
#(
    parameter int LFSR_W    = PKG_LFSR_W,
    parameter int DEPTH     = 64,
    parameter int NUM_PTRN  = PKG_NUM_PTRN,
    parameter int TRAIN_LEN = 10,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64,
    parameter int AW        = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic [3:0]        cfg_ptrn_sel,
    input  logic [LFSR_W-1:0] cfg_seed,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_rd_en,
    input  logic [LFSR_W:0]   mem_rd_data,
    output logic              mem_wr_en,
    output logic [LFSR_W:0]   mem_wr_data,
    output logic              Ack,
    output logic [3:0]        ptrn_found,
    output logic [LFSR_W-1:0] seed_found,
    output logic              err_nomatch,
    output logic [6:0]        par_err_cnt
);

    localparam int BW = LFSR_W + 1;
    localparam int IW = $clog2(DEPTH);
    localparam int TW = $clog2(TRAIN_LEN);

    state_t state, state_n;

    logic              start_q;
    logic              dec_q;
    logic              phase;
    logic [IW-1:0]     idx;
    logic [3:0]        cand;
    logic [TW-1:0]     tidx;

    logic              lfsr_load, lfsr_step;
    logic [LFSR_W-1:0] lfsr_seed, lfsr_state, tap;

    logic              launch;
    logic [LFSR_W-1:0] rd_low, rd_seed, cfg_seed_fix;
    logic [3:0]        cfg_sel_fix;
    logic              train_hit, last_byte, last_train, last_cand;
    logic [LFSR_W-1:0] enc_low;
    logic [BW-1:0]     enc_byte, dec_byte;
    logic              par_bad;

    assign launch       = (state == IDLE) && start_q && !Start;
    assign rd_low       = mem_rd_data[LFSR_W-1:0];
    assign rd_seed      = (rd_low == '0) ? LFSR_W'(1) : rd_low;
    assign cfg_seed_fix = (cfg_seed == '0) ? LFSR_W'(1) : cfg_seed;
    assign cfg_sel_fix  = (int'(cfg_ptrn_sel) < NUM_PTRN) ? cfg_ptrn_sel : 4'd0;

    // During training the candidate drives the taps; otherwise the selected pattern does.
    assign tap = LFSR_W'(ptrn_tap((state == TRAIN) ? cand : ptrn_found));

    assign train_hit  = (rd_low == lfsr_state);
    assign last_byte  = (idx == IW'(DEPTH - 1));
    assign last_train = (tidx == TW'(TRAIN_LEN - 1));
    assign last_cand  = (cand == 4'(NUM_PTRN - 1));

    assign enc_low  = LFSR_W'(mem_rd_data - BW'(ASCII_OFFSET)) ^ lfsr_state;
    assign enc_byte = {^enc_low, enc_low};
    assign dec_byte = {1'b0, rd_low ^ lfsr_state} + BW'(ASCII_OFFSET);
    assign par_bad  = mem_rd_data[BW-1] != ^rd_low;

    lfsr_gen #(.LFSR_W(LFSR_W)) u_lfsr (
        .clk   (Clk),
        .reset (Reset),
        .load  (lfsr_load),
        .seed  (lfsr_seed),
        .step  (lfsr_step),
        .tap   (tap),
        .state (lfsr_state)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        mem_addr    = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        lfsr_load   = 1'b0;
        lfsr_seed   = seed_found;
        lfsr_step   = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_n = Mode ? SEED : RUN;
                    if (!Mode) begin
                        lfsr_load = 1'b1;
                        lfsr_seed = cfg_seed_fix;
                    end
                end
            end
            SEED: begin
                if (!phase) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = AW'(SRC_BASE);
                end else begin
                    lfsr_load = 1'b1;
                    lfsr_seed = rd_seed;
                    state_n   = TRAIN;
                end
            end
            TRAIN: begin
                // Step during the read so the compare cycle sees s_j for byte j.
                if (!phase) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = AW'(SRC_BASE) + AW'(tidx);
                    lfsr_step = 1'b1;
                end else if (!train_hit) begin
                    lfsr_load = 1'b1;
                    if (last_cand) state_n = DONE;
                end else if (last_train) begin
                    lfsr_load = 1'b1;
                    state_n   = RUN;
                end
            end
            RUN: begin
                if (!phase) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = AW'(SRC_BASE) + AW'(idx);
                end else begin
                    mem_wr_en   = 1'b1;
                    mem_addr    = AW'(DST_BASE) + AW'(idx);
                    mem_wr_data = dec_q ? dec_byte : enc_byte;
                    lfsr_step   = 1'b1;
                    if (last_byte) state_n = DONE;
                end
            end
            DONE: begin
                if (Start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            start_q     <= 1'b0;
            dec_q       <= 1'b0;
            phase       <= 1'b0;
            idx         <= '0;
            cand        <= '0;
            tidx        <= TW'(1);
            Ack         <= 1'b0;
            ptrn_found  <= '0;
            seed_found  <= '0;
            err_nomatch <= 1'b0;
            par_err_cnt <= '0;
        end else begin
            start_q <= Start;
            case (state)
                IDLE: begin
                    if (launch) begin
                        dec_q       <= Mode;
                        phase       <= 1'b0;
                        idx         <= '0;
                        cand        <= '0;
                        tidx        <= TW'(1);
                        Ack         <= 1'b0;
                        err_nomatch <= 1'b0;
                        par_err_cnt <= '0;
                        ptrn_found  <= Mode ? 4'd0 : cfg_sel_fix;
                        seed_found  <= Mode ? '0 : cfg_seed_fix;
                    end
                end
                SEED: begin
                    phase <= ~phase;
                    if (phase) seed_found <= rd_seed;
                end
                TRAIN: begin
                    phase <= ~phase;
                    if (phase) begin
                        if (!train_hit) begin
                            tidx <= TW'(1);
                            if (last_cand) begin
                                err_nomatch <= 1'b1;
                                Ack         <= 1'b1;
                            end else begin
                                cand <= cand + 4'd1;
                            end
                        end else if (last_train) begin
                            ptrn_found <= cand;
                        end else begin
                            tidx <= tidx + TW'(1);
                        end
                    end
                end
                RUN: begin
                    phase <= ~phase;
                    if (phase) begin
                        idx <= idx + IW'(1);
                        if (dec_q && par_bad && par_err_cnt != 7'h7F)
                            par_err_cnt <= par_err_cnt + 7'd1;
                        if (last_byte) Ack <= 1'b1;
                    end
                end
                DONE: begin
                    if (Start) Ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// Randomized bench for lfsr_crypt_engine against a keystream/message reference model.
module tb_lfsr_crypt_engine;

    localparam int DEPTH   = 64;
    localparam int NP      = 9;
    localparam int TL      = 10;
    localparam int DEC_MAX = 2 + 2*NP*(TL-1) + 2*DEPTH + 1;

    logic       clk = 1'b0;
    logic       reset, start, mode;
    logic [3:0] cfg_ptrn_sel;
    logic [6:0] cfg_seed;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
    logic       mem_rd_en, mem_wr_en, ack;
    logic [3:0] ptrn_found;
    logic [6:0] seed_found, par_err_cnt;
    logic       err_nomatch;

    always #5 clk = ~clk;

    lfsr_crypt_engine dut (
        .Clk(clk), .Reset(reset), .Start(start), .Mode(mode),
        .cfg_ptrn_sel(cfg_ptrn_sel), .cfg_seed(cfg_seed),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .Ack(ack),
        .ptrn_found(ptrn_found), .seed_found(seed_found),
        .err_nomatch(err_nomatch), .par_err_cnt(par_err_cnt)
    );

    logic [6:0] taps [NP] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    logic [7:0] src_mem [DEPTH];
    logic [7:0] dst_mem [DEPTH];
    logic [7:0] pt [DEPTH];
    logic [7:0] ct [DEPTH];
    logic [7:0] img [DEPTH];
    logic [7:0] exp_out [DEPTH];
    logic [6:0] ks [DEPTH];

    int   n_chk = 0, n_err = 0;
    int   wr_cnt = 0, both_cnt = 0, stray_cnt = 0, run_wr = 0;
    logic clr_dst = 1'b0;

    // Memory: one-cycle read latency; source at 0..63, destination at 64..127.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= (mem_addr < 8'(DEPTH)) ? src_mem[mem_addr[5:0]] : 8'h00;
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
        if (mem_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (mem_addr >= 8'd64 && mem_addr < 8'd128) dst_mem[mem_addr[5:0]] <= mem_wr_data;
            else stray_cnt <= stray_cnt + 1;
        end
        if (clr_dst) for (int i = 0; i < DEPTH; i++) dst_mem[i] <= 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Keystream s_0..s_63 for a seed and tap pattern.
    function automatic void fill_ks(input logic [6:0] seed, input logic [6:0] t);
        logic [6:0] s;
        s = seed;
        for (int i = 0; i < DEPTH; i++) begin
            ks[i] = s;
            s = {s[5:0], ^(s & t)};
        end
    endfunction

    function automatic void model_encrypt(input logic [6:0] seed, input logic [6:0] t);
        logic [7:0] d;
        logic [6:0] c;
        fill_ks((seed == 7'd0) ? 7'd1 : seed, t);
        for (int i = 0; i < DEPTH; i++) begin
            d = pt[i] - 8'h20;
            c = d[6:0] ^ ks[i];
            ct[i] = {^c, c};
        end
    endfunction

    function automatic logic [6:0] img_seed();
        logic [7:0] b;
        b = img[0];
        return (b[6:0] == 7'd0) ? 7'd1 : b[6:0];
    endfunction

    // Lowest pattern whose keystream reproduces preamble bytes 1..TL-1, or -1.
    function automatic int model_find();
        logic [7:0] b;
        bit ok;
        for (int k = 0; k < NP; k++) begin
            fill_ks(img_seed(), taps[k]);
            ok = 1'b1;
            for (int j = 1; j < TL; j++) begin
                b = img[j];
                if (b[6:0] != ks[j]) ok = 1'b0;
            end
            if (ok) return k;
        end
        return -1;
    endfunction

    function automatic void model_decrypt(input int k);
        logic [7:0] b, t;
        fill_ks(img_seed(), taps[k]);
        for (int i = 0; i < DEPTH; i++) begin
            b = img[i];
            t = {1'b0, b[6:0] ^ ks[i]};
            exp_out[i] = t + 8'h20;
        end
    endfunction

    function automatic int dst_ok();
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) if (dst_mem[i] === exp_out[i]) n++;
        return n;
    endfunction

    task automatic load_src();
        for (int i = 0; i < DEPTH; i++) src_mem[i] = img[i];
    endtask

    task automatic run(input logic m, input logic [3:0] sel, input logic [6:0] sd, output int lat);
        int w0;
        mode = m; cfg_ptrn_sel = sel; cfg_seed = sd;
        @(negedge clk); start = 1'b1; clr_dst = 1'b1;
        @(negedge clk); start = 1'b0; clr_dst = 1'b0; w0 = wr_cnt;
        lat = 0;
        do begin
            @(posedge clk); lat++; #1;
        end while (!ack && lat < 400);
        chk("ack_seen", ack, 1);
        run_wr = wr_cnt - w0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string msg;
        int lat, ek, w, v, sel;
        logic [6:0] sd;
        bit found;

        reset = 1'b1; start = 1'b0; mode = 1'b0; cfg_ptrn_sel = '0; cfg_seed = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ptrn", ptrn_found, 0);
        chk("rst_seed", seed_found, 0);
        chk("rst_nomatch", err_nomatch, 0);
        chk("rst_par", par_err_cnt, 0);
        @(negedge clk); reset = 1'b0;

        msg = "Mr. Watson, come here. I want to see you.";
        for (int i = 0; i < DEPTH; i++)
            pt[i] = (i >= 10 && i - 10 < msg.len()) ? 8'(msg[i-10]) : 8'h20;

        // Directed encrypt, tap index 3, seed 1.
        model_encrypt(7'h01, taps[3]);
        img = pt; load_src();
        run(1'b0, 4'd3, 7'h01, lat);
        exp_out = ct;
        chk("enc_lat", lat, 2*DEPTH + 1);
        chk("enc_dst", dst_ok(), DEPTH);
        chk("enc_wr", run_wr, DEPTH);
        chk("enc_ptrn", ptrn_found, 3);
        chk("enc_seed", seed_found, 1);
        repeat (3) @(negedge clk);
        chk("ack_hold", ack, 1);

        // Decrypt the directed ciphertext.
        img = ct; load_src();
        run(1'b1, 4'd0, 7'h00, lat);
        exp_out = pt;
        chk("dec_dst", dst_ok(), DEPTH);
        chk("dec_ptrn", ptrn_found, 3);
        chk("dec_ptrn_model", ptrn_found, model_find());
        chk("dec_seed", seed_found, 1);
        chk("dec_par", par_err_cnt, 0);
        chk("dec_nomatch", err_nomatch, 0);
        chk("dec_lat_bound", lat <= DEC_MAX, 1);

        // Parity errors in bytes 20 and 40 do not disturb decryption.
        img = ct; img[20][7] = ~img[20][7]; img[40][7] = ~img[40][7]; load_src();
        run(1'b1, 4'd0, 7'h00, lat);
        exp_out = pt;
        chk("par_dst", dst_ok(), DEPTH);
        chk("par_cnt", par_err_cnt, 2);

        // Every pattern with a random nonzero seed and random text.
        for (int k = 0; k < NP; k++) begin
            sd = 7'($urandom_range(1, 127));
            for (int i = 10; i < DEPTH; i++) pt[i] = 8'($urandom_range(32, 126));
            model_encrypt(sd, taps[k]);
            img = ct; load_src();
            ek = model_find();
            model_decrypt(ek);
            run(1'b1, 4'($urandom_range(0, 15)), 7'($urandom), lat);
            chk("rnd_ptrn", ptrn_found, ek);
            chk("rnd_seed", seed_found, sd);
            chk("rnd_dst", dst_ok(), DEPTH);
            chk("rnd_par", par_err_cnt, 0);
            chk("rnd_lat_bound", lat <= DEC_MAX, 1);
        end

        // Random encrypt configs, including out-of-range selects and zero seed.
        for (int r = 0; r < 4; r++) begin
            sel = (r == 0) ? 12 : int'($urandom_range(0, 15));
            sd  = (r == 1) ? 7'd0 : 7'($urandom);
            for (int i = 10; i < DEPTH; i++) pt[i] = 8'($urandom_range(32, 126));
            model_encrypt(sd, taps[(sel < NP) ? sel : 0]);
            img = pt; load_src();
            run(1'b0, 4'(sel), sd, lat);
            exp_out = ct;
            chk("renc_dst", dst_ok(), DEPTH);
            chk("renc_ptrn", ptrn_found, (sel < NP) ? sel : 0);
            chk("renc_seed", seed_found, (sd == 7'd0) ? 7'd1 : sd);
            chk("renc_lat", lat, 2*DEPTH + 1);
        end

        // Preamble byte 5 corrupted so that no candidate is consistent.
        img = ct;
        for (v = 0; v < 128; v++) begin
            img[5] = {1'b0, 7'(v)};
            if (model_find() < 0) break;
        end
        load_src();
        run(1'b1, 4'd0, 7'h00, lat);
        chk("nm_flag", err_nomatch, 1);
        chk("nm_wr", run_wr, 0);
        chk("nm_lat_bound", lat <= DEC_MAX, 1);

        // Reset in the middle of RUN, then relaunch.
        for (int i = 0; i < DEPTH; i++) pt[i] = (i >= 10 && i - 10 < msg.len()) ? 8'(msg[i-10]) : 8'h20;
        model_encrypt(7'h01, taps[3]);
        img = pt; load_src();
        mode = 1'b0; cfg_ptrn_sel = 4'd3; cfg_seed = 7'h01;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; w = wr_cnt;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (mem_rd_en && mem_addr == 8'd30) found = 1'b1;
        end
        chk("mid_reach", found, 1);
        chk("mid_pre_wr", wr_cnt - w, 30);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_ack", ack, 0);
        chk("mid_rd_en", mem_rd_en, 0);
        chk("mid_wr_en", mem_wr_en, 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_wdata", mem_wr_data, 0);
        chk("mid_ptrn", ptrn_found, 0);
        chk("mid_seed", seed_found, 0);
        w = wr_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_no_wr", wr_cnt - w, 0);
        run(1'b0, 4'd3, 7'h01, lat);
        exp_out = ct;
        chk("relaunch_dst", dst_ok(), DEPTH);
        chk("relaunch_lat", lat, 2*DEPTH + 1);

        chk("rd_wr_excl", both_cnt, 0);
        chk("stray_wr", stray_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lfsr_crypt_engine.md
Name: lfsr_crypt_engine

Overview:
- Hardware replacement for the software encrypt/decrypt programs.
- Streams a padded message through a byte memory port and XORs each byte with a W-bit maximal-length LFSR sequence.
  - Encrypt mode: tap pattern and seed are supplied.
  - Decrypt mode: seed and tap pattern are recovered from the known all-space preamble.
- Sits beside TopLevel's data memory and uses the same Start/Ack launch handshake as the program-driven core.

Parameters:
- LFSR_W, 7, LFSR state width; byte width is LFSR_W+1, with the MSB carrying parity.
- DEPTH, 64, bytes per message (padded length).
- NUM_PTRN, 9, number of candidate tap patterns held in the package table.
- TRAIN_LEN, 10, preamble bytes used to confirm a candidate pattern (minimum pre_length).
- SRC_BASE, 0, source base address.
- DST_BASE, 64, destination base address.
- AW, 8, memory address width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high; all state returns to IDLE.
- Start  in  1  high holds engine idle; first cycle low after high launches a run.
- Mode  in  1  0 = encrypt, 1 = decrypt; sampled at launch.
- cfg_ptrn_sel  in  4  encrypt tap-pattern index; sampled at launch.
- cfg_seed  in  LFSR_W  encrypt seed; sampled at launch, zero is forced to 1.
- mem_addr  out  AW  read/write address.
- mem_rd_en  out  1  read strobe; data is valid on mem_rd_data one cycle later.
- mem_rd_data  in  LFSR_W+1  read data.
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  LFSR_W+1  write data.
- Ack  out  1  run complete.
- ptrn_found  out  4  pattern index used for the run (decrypt: recovered).
- seed_found  out  LFSR_W  seed used for the run.
- err_nomatch  out  1  decrypt found no consistent pattern.
- par_err_cnt  out  7  count of decrypted bytes with bad parity (saturating).

Behaviour:
- Reset: Ack=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, ptrn_found=0, seed_found=0, err_nomatch=0, par_err_cnt=0, state=IDLE. Reset mid-run aborts immediately; no further writes.
- LFSR step: next = {s[LFSR_W-2:0], ^(s & tap)}. Byte i uses state s_i, with s_0 = seed.
- States:
  - IDLE: waits for Start high then low.
  - SEED: decrypt only.
  - TRAIN: decrypt only.
  - RUN.
  - DONE.
- IDLE -> RUN (encrypt) or IDLE -> SEED (decrypt) on launch. Launch clears Ack, err_nomatch and par_err_cnt.
- SEED (2 cycles): read SRC_BASE+0. Seed = low LFSR_W bits; a zero seed is forced to 1.
- TRAIN:
  - For candidate k = 0..NUM_PTRN-1: read bytes 1..TRAIN_LEN-1 and compare the low bits to the LFSR states stepped with tap[k].
  - First mismatch aborts k: reload seed, move to k+1.
  - All TRAIN_LEN bytes matching selects k and moves to RUN.
  - Exhausting all candidates sets err_nomatch=1 and moves to DONE with zero writes.
  - Lowest matching k wins.
- RUN: each byte takes 2 cycles (read, then write); the write address is DST_BASE+i.
  - Encrypt: c = (p - 0x20)[LFSR_W-1:0] ^ s_i; write {^c, c}.
  - Decrypt: d = (x[LFSR_W-1:0] ^ s_i) + 0x20, modulo 2^(LFSR_W+1); write d.
  - Decrypt parity: if x[MSB] != ^x[LFSR_W-1:0], par_err_cnt++ (saturates at 127); decryption proceeds regardless.
- Address arithmetic wraps modulo 2^AW.
- Read and write are never asserted in the same cycle.
- RUN ends after byte DEPTH-1 is written -> DONE.
- DONE: Ack=1, held until Start goes high, then -> IDLE with Ack=0. Result outputs hold until the next launch.
- Start asserted during SEED, TRAIN or RUN is ignored.
- cfg_ptrn_sel >= NUM_PTRN is treated as 0.
- Latency:
  - Encrypt: Ack rises 2*DEPTH+1 cycles after launch.
  - Decrypt: Ack rises at most 2 + 2*NUM_PTRN*(TRAIN_LEN-1) + 2*DEPTH + 1 cycles after launch.

Decomposition:
- Package lfsr_crypt_pkg holds:
  - LFSR_PTRN table: 60, 48, 78, 72, 6A, 69, 5C, 7E, 7B (hex).
  - ASCII_OFFSET = 0x20.
  - State enum {IDLE, SEED, TRAIN, RUN, DONE}.
- Sub-module lfsr_gen (parametrised by LFSR_W):
  - Inputs: load, seed, step, tap.
  - Output: registered state.
  - Sync reset to 1.

Test Plan:
- Encrypt, tap 0x72 (index 3), seed 0x01, source = 10 bytes 0x20 then "Mr. Watson..." padded with 0x20 -> DST matches the bench golden model (parity in MSB) for all 64 bytes; Ack at cycle 129 after launch.
- Decrypt the above ciphertext -> DST = padded plaintext; ptrn_found=3, seed_found=01, par_err_cnt=0, err_nomatch=0.
- Decrypt with each of the 9 patterns and random nonzero seeds -> ptrn_found equals the pattern actually used; 64/64 bytes correct.
- Flip bit 7 of ciphertext bytes 20 and 40 -> plaintext still correct; par_err_cnt=2.
- Corrupt preamble byte 5 so that no pattern is consistent -> err_nomatch=1, no mem_wr_en pulses, Ack asserted.
- Assert Reset mid-RUN at byte 30 -> outputs return to reset values next cycle, no further writes; a relaunch completes normally.
